// File: rtl/riscv_params_pkg.sv
// rtl/riscv_params_pkg.sv - shared SimpleRISC widths, control bundles and EX-stage enums
package riscv_params_pkg;

    localparam int INSTR_WIDTH = 32;
    localparam int ADDR_WIDTH  = 4;
    localparam int DIV_CYCLES  = 32;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
        logic branch;
        logic alu_src;
        logic is_call;
        logic is_ret;
    } control_signal;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] rs1;
        logic [ADDR_WIDTH-1:0] rs2;
        logic [ADDR_WIDTH-1:0] rd;
    } address_reg;

    typedef enum logic [4:0] {
        ADD, SUB, MUL, DIV, MOD, CMP, AND, OR, NOT, MOV, LSL, LSR, ASR,
        NOP, LD, ST, BEQ, BGT, B, CALL, RET
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } ex_state_t;

    // Two's-complement magnitude; 32'h8000_0000 maps to itself, which reads correctly as unsigned 2^31
    function automatic logic [INSTR_WIDTH-1:0] magnitude(input logic [INSTR_WIDTH-1:0] v);
        return v[INSTR_WIDTH-1] ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/execute_unit_divider.sv
// rtl/execute_unit_divider.sv - iterative restoring signed divider for DIV/MOD
module iter_divider
    import riscv_params_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic [INSTR_WIDTH-1:0] op_a,
    input  logic [INSTR_WIDTH-1:0] op_b,
    input  logic                   is_mod,
    output logic                   busy,
    output logic                   done,
    output logic [INSTR_WIDTH-1:0] result
);
    localparam int W  = INSTR_WIDTH;
    localparam int CW = $clog2(DIV_CYCLES);

    ex_state_t      state_q, state_d;
    logic [W-1:0]   rem_q, rem_d;
    logic [W-1:0]   quo_q, quo_d;
    logic [W-1:0]   dvs_q, dvs_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           q_neg_q, q_neg_d;
    logic           r_neg_q, r_neg_d;
    logic           mod_q, mod_d;
    logic [W:0]     shifted;
    logic [W:0]     diff;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            mod_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            mod_q   <= mod_d;
        end
    end

    // Next-state: abort wins over the natural RUN/DONE progression
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (abort) state_d = IDLE;
                     else if (cnt_q == '0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: latch magnitudes on start, one restoring step per RUN cycle
    always_comb begin
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        mod_d   = mod_q;
        shifted = {rem_q, quo_q[W-1]};
        diff    = shifted - {1'b0, dvs_q};
        if (state_q == IDLE && start) begin
            rem_d   = '0;
            quo_d   = magnitude(op_a);
            dvs_d   = magnitude(op_b);
            cnt_d   = CW'(DIV_CYCLES - 1);
            q_neg_d = op_a[W-1] ^ op_b[W-1];
            r_neg_d = op_a[W-1];
            mod_d   = is_mod;
        end else if (state_q == RUN) begin
            if (!diff[W]) begin
                rem_d = diff[W-1:0];
                quo_d = {quo_q[W-2:0], 1'b1};
            end else begin
                rem_d = shifted[W-1:0];
                quo_d = {quo_q[W-2:0], 1'b0};
            end
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Outputs: busy covers RUN and DONE, result is sign-corrected in DONE
    always_comb begin
        busy   = (state_q != IDLE);
        done   = (state_q == DONE);
        if (mod_q) result = r_neg_q ? (~rem_q + 1'b1) : rem_q;
        else       result = q_neg_q ? (~quo_q + 1'b1) : quo_q;
    end

endmodule

// File: rtl/execute_unit.sv
// rtl/execute_unit.sv - SimpleRISC EX stage: ALU, flags, branch resolve, EX/MEM registers
module execute_unit
    import riscv_params_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic                   flush,
    input  alu_op_t                alu_op,
    input  logic [INSTR_WIDTH-1:0] op_a,
    input  logic [INSTR_WIDTH-1:0] op_b,
    input  logic [INSTR_WIDTH-1:0] op2_in,
    input  logic [ADDR_WIDTH-1:0]  rd_in,
    input  logic [INSTR_WIDTH-1:0] pc_in,
    input  logic [INSTR_WIDTH-1:0] br_target,
    input  control_signal          ctrl_sig_in,
    input  address_reg             addr_reg_in,
    output logic                   ex_busy,
    output control_signal          ctrl_sig_reg,
    output logic [INSTR_WIDTH-1:0] aluResult,
    output logic [INSTR_WIDTH-1:0] op2,
    output logic [ADDR_WIDTH-1:0]  rd_out,
    output logic [INSTR_WIDTH-1:0] pc_out,
    output address_reg             address_reg_out,
    output logic                   br_taken,
    output logic [INSTR_WIDTH-1:0] br_pc
);
    localparam int W = INSTR_WIDTH;

    logic accept, is_divmod, div_start, div_busy, div_done, take;
    logic [W-1:0] alu_res, target, div_result;

    control_signal         ctrl_q, ctrl_d, dctrl_q, dctrl_d;
    address_reg            areg_q, areg_d, dareg_q, dareg_d;
    logic [ADDR_WIDTH-1:0] rd_q, rd_d, drd_q, drd_d;
    logic [W-1:0]          alu_q, alu_d, op2_q, op2_d, pc_q, pc_d, dpc_q, dpc_d, brpc_q, brpc_d;
    logic                  brt_q, brt_d, e_q, e_d, gt_q, gt_d;

    assign ex_busy   = div_busy;
    assign accept    = in_valid & ~ex_busy & ~flush;
    assign is_divmod = (alu_op == DIV) || (alu_op == MOD);
    // Divide by zero never enters the iterative path; its result comes from the ALU below
    assign div_start = accept & is_divmod & (op_b != '0);

    iter_divider u_div (
        .clk    (clk),
        .rst    (rst),
        .start  (div_start),
        .abort  (flush),
        .op_a   (op_a),
        .op_b   (op_b),
        .is_mod (alu_op == MOD),
        .busy   (div_busy),
        .done   (div_done),
        .result (div_result)
    );

    // Single-cycle ALU result and branch resolution against the current flags
    always_comb begin
        alu_res = '0;
        take    = 1'b0;
        target  = br_target;
        case (alu_op)
            ADD:     alu_res = op_a + op_b;
            SUB:     alu_res = op_a - op_b;
            MUL:     alu_res = op_a * op_b;
            DIV:     alu_res = '1;
            MOD:     alu_res = op_a;
            AND:     alu_res = op_a & op_b;
            OR:      alu_res = op_a | op_b;
            NOT:     alu_res = ~op_b;
            MOV:     alu_res = op_b;
            LSL:     alu_res = op_a << op_b[4:0];
            LSR:     alu_res = op_a >> op_b[4:0];
            ASR:     alu_res = $unsigned($signed(op_a) >>> op_b[4:0]);
            LD, ST:  alu_res = op_a + op_b;
            BEQ:     take = e_q;
            BGT:     take = gt_q;
            B:       take = 1'b1;
            CALL: begin
                take    = 1'b1;
                alu_res = pc_in + 32'd4;
            end
            RET: begin
                take   = 1'b1;
                target = op_a;
            end
            default: alu_res = '0;
        endcase
    end

    // Next EX/MEM contents: divider completion, accepted op, or bubble
    always_comb begin
        ctrl_d  = '0;
        brt_d   = 1'b0;
        alu_d   = alu_q;
        op2_d   = op2_q;
        rd_d    = rd_q;
        pc_d    = pc_q;
        areg_d  = areg_q;
        brpc_d  = brpc_q;
        e_d     = e_q;
        gt_d    = gt_q;
        dctrl_d = dctrl_q;
        drd_d   = drd_q;
        dpc_d   = dpc_q;
        dareg_d = dareg_q;
        if (div_done && !flush) begin
            ctrl_d = dctrl_q;
            rd_d   = drd_q;
            pc_d   = dpc_q;
            areg_d = dareg_q;
            alu_d  = div_result;
        end else if (div_start) begin
            dctrl_d = ctrl_sig_in;
            drd_d   = rd_in;
            dpc_d   = pc_in;
            dareg_d = addr_reg_in;
        end else if (accept) begin
            ctrl_d = ctrl_sig_in;
            rd_d   = rd_in;
            pc_d   = pc_in;
            areg_d = addr_reg_in;
            alu_d  = alu_res;
            op2_d  = op2_in;
            brt_d  = take;
            if (take) brpc_d = target;
            if (alu_op == CMP) begin
                e_d  = (op_a == op_b);
                gt_d = ($signed(op_a) > $signed(op_b));
            end
        end
    end

    // EX/MEM boundary, flags and the side copy of the in-flight division
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q <= '0; alu_q <= '0; op2_q <= '0; rd_q <= '0; pc_q <= '0;
            areg_q <= '0; brt_q <= 1'b0; brpc_q <= '0; e_q <= 1'b0; gt_q <= 1'b0;
            dctrl_q <= '0; drd_q <= '0; dpc_q <= '0; dareg_q <= '0;
        end else begin
            ctrl_q <= ctrl_d; alu_q <= alu_d; op2_q <= op2_d; rd_q <= rd_d; pc_q <= pc_d;
            areg_q <= areg_d; brt_q <= brt_d; brpc_q <= brpc_d; e_q <= e_d; gt_q <= gt_d;
            dctrl_q <= dctrl_d; drd_q <= drd_d; dpc_q <= dpc_d; dareg_q <= dareg_d;
        end
    end

    assign ctrl_sig_reg    = ctrl_q;
    assign aluResult       = alu_q;
    assign op2             = op2_q;
    assign rd_out          = rd_q;
    assign pc_out          = pc_q;
    assign address_reg_out = areg_q;
    assign br_taken        = brt_q;
    assign br_pc           = brpc_q;

endmodule

// File: tb/tb_execute_unit.sv
// tb/tb_execute_unit.sv - directed self-checking bench for execute_unit
module tb_execute_unit;
    import riscv_params_pkg::*;

    logic          clk = 1'b0;
    logic          rst, in_valid, flush;
    alu_op_t       alu_op;
    logic [31:0]   op_a, op_b, op2_in, pc_in, br_target;
    logic [3:0]    rd_in;
    control_signal ctrl_sig_in;
    address_reg    addr_reg_in;
    logic          ex_busy, br_taken;
    control_signal ctrl_sig_reg;
    logic [31:0]   aluResult, op2, pc_out, br_pc;
    logic [3:0]    rd_out;
    address_reg    address_reg_out;

    int checks = 0;
    int errors = 0;

    localparam control_signal CTRL_A = 8'h81;
    localparam control_signal CTRL_D = 8'hC3;

    execute_unit dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .flush(flush), .alu_op(alu_op),
        .op_a(op_a), .op_b(op_b), .op2_in(op2_in), .rd_in(rd_in), .pc_in(pc_in),
        .br_target(br_target), .ctrl_sig_in(ctrl_sig_in), .addr_reg_in(addr_reg_in),
        .ex_busy(ex_busy), .ctrl_sig_reg(ctrl_sig_reg), .aluResult(aluResult), .op2(op2),
        .rd_out(rd_out), .pc_out(pc_out), .address_reg_out(address_reg_out),
        .br_taken(br_taken), .br_pc(br_pc)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input alu_op_t op, input logic [31:0] a, input logic [31:0] b);
        alu_op   = op;
        op_a     = a;
        op_b     = b;
        in_valid = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; alu_op = NOP;
        op_a = '0; op_b = '0; op2_in = '0; rd_in = 4'd3; pc_in = 32'h200;
        br_target = '0; ctrl_sig_in = CTRL_A; addr_reg_in = 12'h123;
        tick; tick;
        checks++;
        if ({ex_busy, ctrl_sig_reg, aluResult, op2, rd_out, pc_out, address_reg_out, br_taken, br_pc} !== '0) begin
            errors++;
            $display("FAIL reset_state: got busy=%b ctrl=%h alu=%h op2=%h rd=%h pc=%h areg=%h brt=%b brpc=%h, want all 0",
                     ex_busy, ctrl_sig_reg, aluResult, op2, rd_out, pc_out, address_reg_out, br_taken, br_pc);
        end
        rst = 1'b0;
    endtask

    task automatic test_add;
        drive(ADD, 32'd7, 32'd5);
        tick;
        checks++;
        if (aluResult !== 32'd12 || rd_out !== 4'd3 || ctrl_sig_reg !== CTRL_A || pc_out !== 32'h200) begin
            errors++;
            $display("FAIL add: got alu=%h rd=%h ctrl=%h pc=%h, want 0000000c 3 81 00000200",
                     aluResult, rd_out, ctrl_sig_reg, pc_out);
        end
        in_valid = 1'b0;
        tick;
        checks++;
        if (ctrl_sig_reg !== '0 || br_taken !== 1'b0) begin
            errors++;
            $display("FAIL bubble: got ctrl=%h brt=%b, want 00 0", ctrl_sig_reg, br_taken);
        end
    endtask

    task automatic test_alu_ops;
        alu_op_t     ops [6] = '{SUB, MUL, NOT, LSL, LSR, ASR};
        logic [31:0] as  [6] = '{32'd0, 32'hFFFFFFFD, 32'd0, 32'd1, 32'h80000000, 32'h80000000};
        logic [31:0] bs  [6] = '{32'd1, 32'd7, 32'h0F0F0F0F, 32'd31, 32'd4, 32'd4};
        logic [31:0] exp [6] = '{32'hFFFFFFFF, 32'hFFFFFFEB, 32'hF0F0F0F0, 32'h80000000, 32'h08000000, 32'hF8000000};
        for (int i = 0; i < 6; i++) begin
            drive(ops[i], as[i], bs[i]);
            tick;
            checks++;
            if (aluResult !== exp[i]) begin
                errors++;
                $display("FAIL alu_op_%0d: got %h, want %h", i, aluResult, exp[i]);
            end
        end
        in_valid = 1'b0;
        tick;
    endtask

    task automatic test_branch;
        drive(CMP, 32'd3, 32'd3); tick;
        br_target = 32'h40; drive(BEQ, 32'd0, 32'd0); tick;
        checks++;
        if (br_taken !== 1'b1 || br_pc !== 32'h40) begin
            errors++;
            $display("FAIL beq_taken: got brt=%b brpc=%h, want 1 00000040", br_taken, br_pc);
        end
        drive(CMP, 32'd3, 32'd4); tick;
        drive(BEQ, 32'd0, 32'd0); tick;
        checks++;
        if (br_taken !== 1'b0) begin
            errors++;
            $display("FAIL beq_not_taken: got brt=%b, want 0", br_taken);
        end
        drive(CMP, 32'd5, 32'hFFFFFFFF); tick;
        br_target = 32'h80; drive(BGT, 32'd0, 32'd0); tick;
        checks++;
        if (br_taken !== 1'b1 || br_pc !== 32'h80) begin
            errors++;
            $display("FAIL bgt_signed: got brt=%b brpc=%h, want 1 00000080", br_taken, br_pc);
        end
        pc_in = 32'h200; br_target = 32'h300; drive(CALL, 32'd0, 32'd0); tick;
        checks++;
        if (br_taken !== 1'b1 || br_pc !== 32'h300 || aluResult !== 32'h204) begin
            errors++;
            $display("FAIL call: got brt=%b brpc=%h alu=%h, want 1 00000300 00000204", br_taken, br_pc, aluResult);
        end
        drive(RET, 32'h1234, 32'd0); tick;
        checks++;
        if (br_taken !== 1'b1 || br_pc !== 32'h1234) begin
            errors++;
            $display("FAIL ret: got brt=%b brpc=%h, want 1 00001234", br_taken, br_pc);
        end
        in_valid = 1'b0; tick;
        checks++;
        if (br_taken !== 1'b0) begin
            errors++;
            $display("FAIL br_pulse: got brt=%b, want 0", br_taken);
        end
    endtask

    task automatic test_flags_hold;
        br_target = 32'h44;
        drive(CMP, 32'd9, 32'd9); tick;
        drive(ADD, 32'd1, 32'd1); tick;
        flush = 1'b1; drive(CMP, 32'd1, 32'd2); tick;
        checks++;
        if (ctrl_sig_reg !== '0) begin
            errors++;
            $display("FAIL flushed_cmp_bubble: got ctrl=%h, want 00", ctrl_sig_reg);
        end
        flush = 1'b0; drive(BEQ, 32'd0, 32'd0); tick;
        checks++;
        if (br_taken !== 1'b1 || br_pc !== 32'h44) begin
            errors++;
            $display("FAIL flags_hold: got brt=%b brpc=%h, want 1 00000044", br_taken, br_pc);
        end
        in_valid = 1'b0; tick;
    endtask

    task automatic test_div;
        alu_op_t     ops [5] = '{DIV, MOD, DIV, MOD, DIV};
        logic [31:0] as  [5] = '{32'hFFFFFFEF, 32'hFFFFFFEF, 32'h80000000, 32'h80000000, 32'd100};
        logic [31:0] bs  [5] = '{32'd5, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd7};
        logic [31:0] exp [5] = '{32'hFFFFFFFD, 32'hFFFFFFFE, 32'h80000000, 32'd0, 32'd14};
        int n, busy_cnt, bad;
        for (int i = 0; i < 5; i++) begin
            ctrl_sig_in = CTRL_D; rd_in = 4'd9;
            drive(ops[i], as[i], bs[i]);
            tick;
            in_valid = 1'b0; ctrl_sig_in = CTRL_A; rd_in = 4'd3;
            n = 1; busy_cnt = 0; bad = 0;
            while (ex_busy && n < 50) begin
                busy_cnt++;
                if (ctrl_sig_reg !== '0) bad++;
                tick;
                n++;
            end
            checks++;
            if (busy_cnt != 33 || n != 34 || bad != 0) begin
                errors++;
                $display("FAIL div_timing_%0d: got busy=%0d latency=%0d early_valid=%0d, want 33 34 0", i, busy_cnt, n, bad);
            end
            checks++;
            if (aluResult !== exp[i] || ctrl_sig_reg !== CTRL_D || rd_out !== 4'd9) begin
                errors++;
                $display("FAIL div_result_%0d: got alu=%h ctrl=%h rd=%h, want %h c3 9", i, aluResult, ctrl_sig_reg, rd_out, exp[i]);
            end
        end
        tick;
    endtask

    task automatic test_div_zero;
        drive(DIV, 32'd9, 32'd0); tick;
        checks++;
        if (aluResult !== 32'hFFFFFFFF || ex_busy !== 1'b0 || ctrl_sig_reg !== CTRL_A) begin
            errors++;
            $display("FAIL div_zero: got alu=%h busy=%b ctrl=%h, want ffffffff 0 81", aluResult, ex_busy, ctrl_sig_reg);
        end
        drive(MOD, 32'd9, 32'd0); tick;
        checks++;
        if (aluResult !== 32'd9 || ex_busy !== 1'b0) begin
            errors++;
            $display("FAIL mod_zero: got alu=%h busy=%b, want 00000009 0", aluResult, ex_busy);
        end
        in_valid = 1'b0; tick;
    endtask

    task automatic test_flush;
        int bad;
        drive(DIV, 32'd100, 32'd7); tick;
        in_valid = 1'b0;
        for (int c = 1; c < 10; c++) tick;
        flush = 1'b1; tick; flush = 1'b0;
        checks++;
        if (ex_busy !== 1'b0 || ctrl_sig_reg !== '0) begin
            errors++;
            $display("FAIL flush_abort: got busy=%b ctrl=%h, want 0 00", ex_busy, ctrl_sig_reg);
        end
        bad = 0;
        for (int c = 0; c < 40; c++) begin
            if (ctrl_sig_reg !== '0 || ex_busy !== 1'b0) bad++;
            tick;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL flush_no_output: got %0d valid/busy cycles, want 0", bad);
        end
        drive(ADD, 32'd1, 32'd2); tick;
        checks++;
        if (aluResult !== 32'd3 || ctrl_sig_reg !== CTRL_A) begin
            errors++;
            $display("FAIL flush_then_add: got alu=%h ctrl=%h, want 00000003 81", aluResult, ctrl_sig_reg);
        end
        in_valid = 1'b0; tick;
    endtask

    task automatic test_store;
        op2_in = 32'hAB;
        drive(ST, 32'h100, 32'd8); tick;
        checks++;
        if (aluResult !== 32'h108 || op2 !== 32'hAB) begin
            errors++;
            $display("FAIL store: got alu=%h op2=%h, want 00000108 000000ab", aluResult, op2);
        end
        in_valid = 1'b0; tick;
    endtask

    task automatic test_rst_mid_div;
        int bad;
        drive(DIV, 32'd100, 32'd7); tick;
        in_valid = 1'b0;
        for (int c = 0; c < 5; c++) tick;
        rst = 1'b1; tick; rst = 1'b0;
        checks++;
        if ({ex_busy, ctrl_sig_reg, aluResult, op2, rd_out, pc_out, address_reg_out, br_taken, br_pc} !== '0) begin
            errors++;
            $display("FAIL rst_mid_div: got busy=%b ctrl=%h alu=%h op2=%h brt=%b, want all 0",
                     ex_busy, ctrl_sig_reg, aluResult, op2, br_taken);
        end
        bad = 0;
        for (int c = 0; c < 40; c++) begin
            if (ctrl_sig_reg !== '0 || ex_busy !== 1'b0) bad++;
            tick;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL rst_no_output: got %0d valid/busy cycles, want 0", bad);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_add;
        test_alu_ops;
        test_branch;
        test_flags_hold;
        test_div;
        test_div_zero;
        test_flush;
        test_store;
        test_rst_mid_div;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
